// File: rtl/tree_result_accumulator_if.sv
// tree_result_accumulator_if: input and output valid/ready streams of the tree result accumulator
interface tree_result_accumulator_if #(
  parameter int DATA_W = 7,
  parameter int ACC_W  = 10
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic [7:0]        out_len;
  logic              out_ovf;
  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_sum, out_len, out_ovf
  );
  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_sum, out_len, out_ovf
  );
endinterface

// File: rtl/tree_result_accumulator.sv
// tree_result_accumulator: sums BLOCK_LEN adder-tree results (or fewer on flush) into one block total.
// Optional macro TREE_ACC_SATURATE_EN: clamp the total at 2^ACC_W-1 and report a sticky overflow;
// without it the total wraps modulo 2^ACC_W and out_ovf stays 0.
module tree_result_accumulator #(
  parameter int DATA_W    = 7,
  parameter int BLOCK_LEN = 8,
  parameter int ACC_W     = 10
) (
  input logic clk,
  input logic rst_n,
  tree_result_accumulator_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;
  state_t           state;
  logic [ACC_W-1:0] acc, acc_nxt, f_acc;
  logic [7:0]       cnt, f_cnt;
  logic             ovf, ovf_nxt, f_ovf, in_fire, close;
`ifdef TREE_ACC_SATURATE_EN
  logic [ACC_W:0]   sum;
`endif
  // next running total, plus the block's final values including any same-cycle beat
  always_comb begin
    in_fire = bus.in_valid && bus.in_ready;
`ifdef TREE_ACC_SATURATE_EN
    sum     = {1'b0, acc} + (ACC_W+1)'(bus.in_data);
    ovf_nxt = ovf | sum[ACC_W];
    acc_nxt = ovf_nxt ? '1 : sum[ACC_W-1:0];
`else
    acc_nxt = acc + ACC_W'(bus.in_data);
    ovf_nxt = 1'b0;
`endif
    f_acc   = in_fire ? acc_nxt : acc;
    f_cnt   = in_fire ? cnt + 8'd1 : cnt;
    f_ovf   = in_fire ? ovf_nxt : ovf;
    close   = state == ACC && (bus.flush || (in_fire && cnt == 8'(BLOCK_LEN - 1)));
  end
  // block FSM: accumulate in IDLE/ACC, present the closed block in HOLD until the sink takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      acc           <= '0;
      cnt           <= '0;
      ovf           <= 1'b0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_sum   <= '0;
      bus.out_len   <= '0;
      bus.out_ovf   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (in_fire) begin
          acc   <= acc_nxt;
          cnt   <= 8'd1;
          ovf   <= ovf_nxt;
          state <= ACC;
        end
        ACC: if (close) begin
          bus.out_sum   <= f_acc;
          bus.out_len   <= f_cnt;
          bus.out_ovf   <= f_ovf;
          bus.out_valid <= 1'b1;
          bus.in_ready  <= 1'b0;
          state         <= HOLD;
        end else if (in_fire) begin
          acc <= acc_nxt;
          cnt <= f_cnt;
          ovf <= ovf_nxt;
        end
        HOLD: if (bus.out_ready) begin
          bus.out_valid <= 1'b0;
          bus.in_ready  <= 1'b1;
          acc           <= '0;
          cnt           <= '0;
          ovf           <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tree_result_accumulator.sv
// tb_tree_result_accumulator: directed and randomized checks of a 10-bit and an 8-bit accumulator side by side
module tb_tree_result_accumulator;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       flush = 1'b0;
  logic       out_ready = 1'b1;
  logic [6:0] in_data = '0;
  int         checks = 0;
  int         failures = 0;
  int         tot = 0;
  int         len = 0;

  always #5 clk = ~clk;

  tree_result_accumulator_if #(.DATA_W(7), .ACC_W(10)) bus_a ();
  tree_result_accumulator_if #(.DATA_W(7), .ACC_W(8))  bus_b ();

  assign bus_a.in_valid  = in_valid;
  assign bus_a.in_data   = in_data;
  assign bus_a.flush     = flush;
  assign bus_a.out_ready = out_ready;
  assign bus_b.in_valid  = in_valid;
  assign bus_b.in_data   = in_data;
  assign bus_b.flush     = flush;
  assign bus_b.out_ready = out_ready;

  tree_result_accumulator #(.DATA_W(7), .BLOCK_LEN(8), .ACC_W(10)) u_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  tree_result_accumulator #(.DATA_W(7), .BLOCK_LEN(8), .ACC_W(8))  u_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int d, input bit fl);
    in_valid = 1'b1;
    in_data  = 7'(d);
    flush    = fl;
    chk("in_ready_a", {31'd0, bus_a.in_ready}, 1);
    chk("in_ready_b", {31'd0, bus_b.in_ready}, 1);
    step();
    in_valid = 1'b0;
    flush    = 1'b0;
    tot += d;
    len++;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid_a"}, {31'd0, bus_a.out_valid}, 0);
    chk({tag, "_valid_b"}, {31'd0, bus_b.out_valid}, 0);
    chk({tag, "_ready_a"}, {31'd0, bus_a.in_ready}, 1);
    chk({tag, "_ready_b"}, {31'd0, bus_b.in_ready}, 1);
  endtask

  // expected block result: wide accumulator never overflows, narrow one wraps or saturates
  task automatic chk_out(input string tag);
    int eb;
    int ob;
`ifdef TREE_ACC_SATURATE_EN
    eb = tot > 255 ? 255 : tot;
    ob = tot > 255 ? 1 : 0;
`else
    eb = tot % 256;
    ob = 0;
`endif
    chk({tag, "_valid_a"}, {31'd0, bus_a.out_valid}, 1);
    chk({tag, "_sum_a"},   {22'd0, bus_a.out_sum}, tot % 1024);
    chk({tag, "_len_a"},   {24'd0, bus_a.out_len}, len);
    chk({tag, "_ovf_a"},   {31'd0, bus_a.out_ovf}, 0);
    chk({tag, "_valid_b"}, {31'd0, bus_b.out_valid}, 1);
    chk({tag, "_sum_b"},   {24'd0, bus_b.out_sum}, eb);
    chk({tag, "_len_b"},   {24'd0, bus_b.out_len}, len);
    chk({tag, "_ovf_b"},   {31'd0, bus_b.out_ovf}, ob);
  endtask

  task automatic take(input string tag);
    out_ready = 1'b1;
    step();
    chk_idle(tag);
  endtask

  initial begin
    #12 rst_n = 1'b1;
    step();
    chk_idle("reset");
    chk("reset_sum_a", {22'd0, bus_a.out_sum}, 0);
    chk("reset_len_b", {24'd0, bus_b.out_len}, 0);
    chk("reset_ovf_b", {31'd0, bus_b.out_ovf}, 0);
    // full block of 100s; output must be valid the cycle after the 8th beat, for one cycle
    tot = 0; len = 0;
    for (int i = 0; i < 8; i++) beat(100, 1'b0);
    chk_out("full");
    step();
    chk_idle("full_after");
    // flush on the third beat
    tot = 0; len = 0;
    beat(5, 1'b0);
    beat(6, 1'b0);
    beat(7, 1'b1);
    chk_out("flush3");
    step();
    chk_idle("flush3_after");
    // flush while idle produces nothing
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk_idle("idle_flush");
    step();
    chk_idle("idle_flush2");
    // flush with no beat in the same cycle closes the partial block
    tot = 0; len = 0;
    for (int i = 0; i < 4; i++) beat(int'($urandom_range(0, 127)), 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk_out("bare_flush");
    take("bare_flush_after");
    // backpressure: held output stable, inputs refused, flush ignored
    out_ready = 1'b0;
    tot = 0; len = 0;
    for (int i = 0; i < 8; i++) beat(int'($urandom_range(0, 127)), 1'b0);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_data  = 7'($urandom_range(0, 127));
      flush    = (i == 4);
      chk_out("hold");
      chk("hold_ready_a", {31'd0, bus_a.in_ready}, 0);
      chk("hold_ready_b", {31'd0, bus_b.in_ready}, 0);
      step();
    end
    in_valid = 1'b0;
    flush = 1'b0;
    chk_out("hold_end");
    take("hold_release");
    // overflow of the narrow accumulator: 4 x 120 = 480
    tot = 0; len = 0;
    for (int i = 0; i < 4; i++) beat(120, i == 3);
    chk_out("ovf");
    step();
    chk_idle("ovf_after");
    // randomized blocks of random length, with random sink stalls
    for (int b = 0; b < 12; b++) begin
      int n;
      int w;
      n = int'($urandom_range(2, 8));
      w = int'($urandom_range(0, 3));
      out_ready = (w == 0);
      tot = 0; len = 0;
      for (int i = 0; i < n; i++) beat(int'($urandom_range(0, 127)), (n < 8) && (i == n - 1));
      for (int i = 0; i < w; i++) begin
        chk_out("rand_wait");
        step();
      end
      chk_out("rand");
      take("rand_after");
    end
    // async reset while an output is pending
    out_ready = 1'b0;
    tot = 0; len = 0;
    for (int i = 0; i < 8; i++) beat(int'($urandom_range(0, 127)), 1'b0);
    chk_out("pre_rst");
    #3 rst_n = 1'b0;
    #1;
    chk_idle("async_rst");
    chk("async_rst_sum_a", {22'd0, bus_a.out_sum}, 0);
    chk("async_rst_len_a", {24'd0, bus_a.out_len}, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    chk_idle("rst_release");
    // reset after 5 beats discards the partial block
    tot = 0; len = 0;
    for (int i = 0; i < 5; i++) beat(int'($urandom_range(0, 127)), 1'b0);
    #3 rst_n = 1'b0;
    #1;
    chk_idle("mid_rst");
    step();
    chk_idle("mid_rst_hold");
    #3 rst_n = 1'b1;
    step();
    chk_idle("mid_rst_release");
    tot = 0; len = 0;
    for (int i = 0; i < 8; i++) beat(1, 1'b0);
    chk_out("after_rst");
    step();
    chk_idle("after_rst_done");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
